// File: rtl/n64_pkg.sv
// Shared definitions for the N64 joybus host: FSM states, command bytes and
// per-bit timing expressed in microseconds.
package n64_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT,
    RX_BIT,
    RX_STOP,
    DONE
  } state_t;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // A bit cell is BIT_US long; the low phase is SHORT_US for a 1, LONG_US for a 0.
  localparam int SHORT_US     = 1;
  localparam int LONG_US      = 3;
  localparam int BIT_US       = 4;
  localparam int RX_SAMPLE_US = 2;

  localparam logic [5:0] RX_MAX_BITS = 6'd32;

  function automatic logic [5:0] clamp_rx_bits(input logic [5:0] bits);
    return (bits > RX_MAX_BITS) ? RX_MAX_BITS : bits;
  endfunction

endpackage

// File: rtl/n64_edge_sync.sv
// Two-flop synchronizer for the idle-high joybus line plus a falling-edge
// detector on the synchronized level; shared by host and device receivers.
module n64_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_async,
  output logic line,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Flops reset high so the released bus never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value, so the chain really is three stages.
      meta <= line_async;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line = sync;
  assign fall = prev & ~sync;

endmodule

// File: rtl/n64_console_host.sv
// Console-side joybus master: sends one command byte plus stop bit, then
// receives a response of up to 32 bits with a per-bit timeout.
module n64_console_host
  import n64_pkg::*;
#(
  parameter int CLKS_PER_US = 4,
  parameter int TIMEOUT_US  = 64
) (
  input  logic        sample_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [5:0]  rx_bits,
  input  logic        data_rx,
  output logic        data_tx,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rx_data
);

  localparam int SHORT_CYC   = SHORT_US * CLKS_PER_US;
  localparam int LONG_CYC    = LONG_US * CLKS_PER_US;
  localparam int BIT_CYC     = BIT_US * CLKS_PER_US;
  localparam int SAMPLE_CYC  = RX_SAMPLE_US * CLKS_PER_US;
  localparam int TIMEOUT_CYC = TIMEOUT_US * CLKS_PER_US;
  localparam int CNT_MAX     = (TIMEOUT_CYC > BIT_CYC) ? TIMEOUT_CYC : BIT_CYC;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  state_t     state, state_n;
  cnt_t       cnt;
  logic [2:0] bit_idx;
  logic [7:0] tx_byte;
  logic [5:0] rx_len;
  logic [5:0] rx_cnt;
  logic       stop_low;

  logic line;
  logic fall;

  logic cnt_clr;
  logic accept;
  logic bit_adv;
  logic shift;
  logic stop_arm;
  logic to_set;

  n64_edge_sync u_edge_sync (
    .clk        (sample_clk),
    .rst_n      (rst_n),
    .line_async (data_rx),
    .line       (line),
    .fall       (fall)
  );

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
    state_n  = state;
    cnt_clr  = 1'b0;
    accept   = 1'b0;
    bit_adv  = 1'b0;
    shift    = 1'b0;
    stop_arm = 1'b0;
    to_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          state_n = TX_BIT;
        end
      end
      TX_BIT: begin
        if (cnt == cnt_t'(BIT_CYC - 1)) begin
          cnt_clr = 1'b1;
          if (bit_idx == 3'd0) state_n = TX_STOP;
          else                 bit_adv = 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt == cnt_t'(LONG_CYC - 1)) begin
          cnt_clr = 1'b1;
          state_n = (rx_len == 6'd0) ? DONE : RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (fall) begin
          cnt_clr = 1'b1;
          state_n = RX_BIT;
        end else if (cnt == cnt_t'(TIMEOUT_CYC - 1)) begin
          to_set  = 1'b1;
          state_n = DONE;
        end
      end
      RX_BIT: begin
        if (cnt == cnt_t'(SAMPLE_CYC - 1)) begin
          shift   = 1'b1;
          cnt_clr = 1'b1;
          state_n = (rx_cnt + 6'd1 == rx_len) ? RX_STOP : RX_WAIT;
        end
      end
      RX_STOP: begin
        // First wait for the device stop bit to fall, then for the line to rise again.
        if (!stop_low) begin
          if (fall) begin
            stop_arm = 1'b1;
            cnt_clr  = 1'b1;
          end else if (cnt == cnt_t'(TIMEOUT_CYC - 1)) begin
            to_set  = 1'b1;
            state_n = DONE;
          end
        end else if (line) begin
          state_n = DONE;
        end else if (cnt == cnt_t'(TIMEOUT_CYC - 1)) begin
          to_set  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= 3'd7;
      tx_byte  <= 8'h00;
      rx_len   <= 6'd0;
      rx_cnt   <= 6'd0;
      stop_low <= 1'b0;
      timeout  <= 1'b0;
      rx_data  <= 32'h0;
    end else begin
      if (cnt_clr)                       cnt <= '0;
      else if (cnt != cnt_t'(CNT_MAX))   cnt <= cnt + cnt_t'(1);

      if (accept) begin
        tx_byte <= cmd;
        rx_len  <= clamp_rx_bits(rx_bits);
        rx_cnt  <= 6'd0;
        bit_idx <= 3'd7;
        timeout <= 1'b0;
        rx_data <= 32'h0;
      end
      if (bit_adv) bit_idx <= bit_idx - 3'd1;
      if (shift) begin
        rx_data  <= {rx_data[30:0], line};
        rx_cnt   <= rx_cnt + 6'd1;
        stop_low <= 1'b0;
      end
      if (stop_arm) stop_low <= 1'b1;
      if (to_set)   timeout  <= 1'b1;
    end
  end

  always_comb begin
    data_tx = 1'b0;
    unique case (state)
      TX_BIT:  data_tx = tx_byte[bit_idx] ? (cnt < cnt_t'(SHORT_CYC)) : (cnt < cnt_t'(LONG_CYC));
      TX_STOP: data_tx = (cnt < cnt_t'(SHORT_CYC));
      default: data_tx = 1'b0;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule

// File: doc/n64_console_host.md
N64_CONSOLE_HOST -- requirements
Module: n64_console_host

Interface
REQ-001 Parameter CLKS_PER_US, default 4, sample_clk cycles per microsecond; legal range 2..64.
REQ-002 Parameter TIMEOUT_US, default 64, microseconds without an expected falling edge before a response is abandoned.
REQ-003 sample_clk  in  1  sole clock, rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  request one transaction; sampled only in IDLE.
REQ-006 cmd  in  8  command byte, captured when start is accepted.
REQ-007 rx_bits  in  6  response length in bits, 0..32, captured with cmd; values above 32 are treated as 32.
REQ-008 data_rx  in  1  raw bus line level, asynchronous to sample_clk.
REQ-009 data_tx  out  1  open-drain enable: 1 = pull line low, 0 = release.
REQ-010 busy  out  1  high from the cycle after start is accepted until done.
REQ-011 done  out  1  one-cycle pulse at transaction end.
REQ-012 timeout  out  1  valid with done; 1 = response incomplete.
REQ-013 rx_data  out  32  response, first received bit at the MSB of the rx_bits-wide field, right-aligned; held until the next accepted start.

Function
REQ-014 States: IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_STOP, DONE.
REQ-015 IDLE: start=1 on a clock edge captures cmd and rx_bits, clears rx_data, and moves to TX_BIT; busy rises next cycle.
REQ-016 start while busy is ignored, with no effect on the transaction in progress.
REQ-017 TX_BIT: 8 bits, MSB first, each exactly 4*CLKS_PER_US cycles; a 0 drives low for 3 us, then releases for 1 us; a 1 drives low for 1 us, then releases for 3 us.
REQ-018 TX_STOP: drive low for 1 us, release for 2 us; then RX_WAIT, or DONE if rx_bits=0 with timeout=0.
REQ-019 data_rx passes through a 2-flop synchronizer; falling edges are detected on the synchronized signal; data_rx is ignored in TX states.
REQ-020 RX_WAIT: a falling edge enters RX_BIT; TIMEOUT_US*CLKS_PER_US cycles with no edge enters DONE with timeout=1.
REQ-021 RX_BIT: sample the synchronized line 2*CLKS_PER_US cycles after the edge (high=1, low=0) and shift it into rx_data LSB; return to RX_WAIT until rx_bits bits are held, then enter RX_STOP.
REQ-022 RX_STOP: a falling edge followed by the line returning high gives DONE with timeout=0; no edge within the timeout, or the line low for more than TIMEOUT_US, gives DONE with timeout=1.
REQ-023 On timeout, rx_data holds the bits received so far, right-aligned.
REQ-024 DONE: done=1 and busy=0 for one cycle, then IDLE; start in that cycle is ignored.
REQ-025 data_tx is 0 in every state except the TX low phases.
REQ-026 Timing counters are sized for 4*64 cycles and the TIMEOUT_US range; they never wrap within a phase.

Reset
REQ-027 rst_n low immediately forces data_tx=0, busy=0, done=0, timeout=0, rx_data=0, synchronizer flops=1 (idle-high bus), state=IDLE.
REQ-028 Reset asserted mid-transaction abandons it with no done pulse; the bus is released within the same cycle.
REQ-029 Exit from reset takes effect on the first sample_clk edge with rst_n high.

Structure
REQ-030 Shared package n64_pkg holds the state enum, command constants (CMD_STATUS 8'h00, CMD_POLL 8'h01, CMD_READ 8'h02, CMD_WRITE 8'h03, CMD_RESET 8'hFF), per-bit microsecond constants (1/3/4) and the RX sample point (2).
REQ-031 Sub-module n64_edge_sync contains the synchronizer and falling-edge detector, and is reusable by the controller-side receiver.

Verification (CLKS_PER_US=4)
REQ-032 cmd=8'h01, rx_bits=0: data_tx low 12/high 4 for seven bits, low 4/high 12 for the last bit, stop low 4/high 8; done 140 cycles after busy rises; timeout=0.
REQ-033 cmd=8'h01, rx_bits=32, bus model replies 32'h8000_0001 plus a stop bit: rx_data=32'h8000_0001, timeout=0.
REQ-034 cmd=8'h00, rx_bits=24, no reply: done 256 cycles after TX stop ends; timeout=1; rx_data=0.
REQ-035 Reply stops after 10 of 32 bits: timeout=1; rx_data holds those 10 bits right-aligned.
REQ-036 rst_n pulsed low during the third TX bit: data_tx=0 and busy=0 immediately, no done; a following start completes normally.
REQ-037 start held high for a whole transaction: exactly one transaction and one done, then a new one starts on the cycle after DONE.
